// File: rtl/ttl_7474_flag_arbiter.sv
// ttl_7474_flag_arbiter
//   Round-robin arbiter and pulse sequencer that owns the control pins of a
//   bank of 7474-style D flip-flops used as flag/semaphore bits. A granted
//   request runs IDLE -> SETUP -> PULSE -> RECOVER -> DONE (reads skip straight
//   from SETUP to DONE) and Q of the target bit is sampled back in DONE.
//
// Ports
//   Clk, Reset            clock, asynchronous active-high reset
//   Req/Op/Idx/Dval       per-requester request, opcode (00 rd, 01 preset,
//                         10 clear, 11 load), bit index, load data
//   Gnt, Done             one-hot grant (grant..DONE), one-cycle completion
//   Rdata                 Q of target bit, captured in DONE (0 for bad Idx)
//   Busy                  high whenever the FSM is not in IDLE
//   Err                   sticky readback mismatch flag (verify build only)
//   FF_D/FF_Clk/Preset_bar/Clear_bar  bank control pins, FF_Q bank readback
//
// Build option
//   TTL_7474_ARB_VERIFY_EN  compares Q against the expected post-operation
//                           value in DONE and sets Err on a mismatch; when
//                           undefined Err is tied low.

// Per-bit pin driver: D latch-up at grant, one control pin asserted for the
// pulse window, everything released together at the end of the window.
module ttl_7474_flag_arbiter_bit (
  input  logic Clk,
  input  logic Reset,
  input  logic d_wr,
  input  logic d,
  input  logic set_pre,
  input  logic set_clr,
  input  logic set_clk,
  input  logic release_pins,
  output logic FF_D,
  output logic FF_Clk,
  output logic Preset_bar,
  output logic Clear_bar
);
  // Reset releases every pin immediately and never touches the bank contents.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      FF_D       <= 1'b0;
      FF_Clk     <= 1'b0;
      Preset_bar <= 1'b1;
      Clear_bar  <= 1'b1;
    end else begin
      if (d_wr) FF_D <= d;
      if (release_pins) begin
        FF_Clk     <= 1'b0;
        Preset_bar <= 1'b1;
        Clear_bar  <= 1'b1;
      end else begin
        if (set_clk) FF_Clk     <= 1'b1;
        if (set_pre) Preset_bar <= 1'b0;
        if (set_clr) Clear_bar  <= 1'b0;
      end
    end
  end
endmodule

module ttl_7474_flag_arbiter #(
  parameter int BLOCKS         = 2,
  parameter int REQUESTERS     = 4,
  parameter int PULSE_CYCLES   = 2,
  parameter int RECOVER_CYCLES = 1,
  parameter int IDXW           = 3
) (
  input  logic                                 Clk,
  input  logic                                 Reset,
  input  logic [REQUESTERS-1:0]                Req,
  input  logic [REQUESTERS-1:0][1:0]           Op,
  input  logic [REQUESTERS-1:0][IDXW-1:0]      Idx,
  input  logic [REQUESTERS-1:0]                Dval,
  output logic [REQUESTERS-1:0]                Gnt,
  output logic [REQUESTERS-1:0]                Done,
  output logic                                 Rdata,
  output logic                                 Busy,
  output logic                                 Err,
  output logic [BLOCKS-1:0]                    FF_D,
  output logic [BLOCKS-1:0]                    FF_Clk,
  output logic [BLOCKS-1:0]                    Preset_bar,
  output logic [BLOCKS-1:0]                    Clear_bar,
  input  logic [BLOCKS-1:0]                    FF_Q
);
  localparam int PW = $clog2(REQUESTERS);
  localparam int CW = $clog2(PULSE_CYCLES + RECOVER_CYCLES + 1) + 1;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_PRESET = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_LOAD   = 2'b11;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_PULSE   = 3'd2;
  localparam logic [2:0] S_RECOVER = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]      state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   ptr, pick, cand;
  logic            any_req;
  logic [1:0]      op_sel, op_q;
  logic [IDXW-1:0] idx_sel, idx_q;
  logic            dval_sel, ok_sel, ok_q, q_sel;
  logic            pulse_last, recover_last, release_pins;
  logic [BLOCKS-1:0] d_wr, set_pre, set_clr, set_clk;

  // First requesting index at or after ptr, wrapping.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    cand    = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      cand = PW'((int'(ptr) + k) % REQUESTERS);
      if (!any_req && Req[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  assign op_sel   = Op[pick];
  assign idx_sel  = Idx[pick];
  assign dval_sel = Dval[pick];
  assign ok_sel   = int'(idx_sel) < BLOCKS;

  assign pulse_last   = int'(cnt) == PULSE_CYCLES - 1;
  assign recover_last = int'(cnt) == RECOVER_CYCLES - 1;
  assign release_pins = (state == S_PULSE) && pulse_last;

  // Out-of-range indices read back as 0.
  always_comb begin
    q_sel = 1'b0;
    for (int b = 0; b < BLOCKS; b++)
      if (ok_q && idx_q == IDXW'(b)) q_sel = FF_Q[b];
  end

  // D is written at grant so it is stable a full SETUP cycle before FF_Clk
  // rises; pins assert on the SETUP->PULSE edge.
  always_comb begin
    for (int b = 0; b < BLOCKS; b++) begin
      d_wr[b]    = (state == S_IDLE) && any_req && ok_sel &&
                   (op_sel == OP_LOAD) && (idx_sel == IDXW'(b));
      set_pre[b] = (state == S_SETUP) && (op_q == OP_PRESET) && (idx_q == IDXW'(b));
      set_clr[b] = (state == S_SETUP) && (op_q == OP_CLEAR)  && (idx_q == IDXW'(b));
      set_clk[b] = (state == S_SETUP) && (op_q == OP_LOAD)   && (idx_q == IDXW'(b));
    end
  end

  ttl_7474_flag_arbiter_bit u_bit [BLOCKS-1:0] (
    .Clk          (Clk),
    .Reset        (Reset),
    .d_wr         (d_wr),
    .d            (dval_sel),
    .set_pre      (set_pre),
    .set_clr      (set_clr),
    .set_clk      (set_clk),
    .release_pins (release_pins),
    .FF_D         (FF_D),
    .FF_Clk       (FF_Clk),
    .Preset_bar   (Preset_bar),
    .Clear_bar    (Clear_bar)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      ptr   <= '0;
      op_q  <= OP_READ;
      idx_q <= '0;
      ok_q  <= 1'b0;
      Gnt   <= '0;
      Done  <= '0;
      Rdata <= 1'b0;
      Busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (any_req) begin
          state <= S_SETUP;
          Busy  <= 1'b1;
          Gnt   <= REQUESTERS'(1) << pick;
          // A bad index degrades to a read so no pin can be touched.
          op_q  <= ok_sel ? op_sel : OP_READ;
          idx_q <= idx_sel;
          ok_q  <= ok_sel;
          ptr   <= (int'(pick) == REQUESTERS - 1) ? '0 : pick + 1'b1;
        end
        S_SETUP: begin
          cnt <= '0;
          if (op_q == OP_READ) begin
            state <= S_DONE;
            Done  <= Gnt;
          end else begin
            state <= S_PULSE;
          end
        end
        S_PULSE: if (pulse_last) begin
          cnt <= '0;
          if (RECOVER_CYCLES == 0) begin
            state <= S_DONE;
            Done  <= Gnt;
          end else begin
            state <= S_RECOVER;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_RECOVER: if (recover_last) begin
          state <= S_DONE;
          Done  <= Gnt;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          Done  <= '0;
          Gnt   <= '0;
          Busy  <= 1'b0;
          Rdata <= q_sel;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TTL_7474_ARB_VERIFY_EN
  logic dval_q, q_exp;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) dval_q <= 1'b0;
    else if (state == S_IDLE && any_req) dval_q <= dval_sel;
  end

  always_comb begin
    case (op_q)
      OP_PRESET: q_exp = 1'b1;
      OP_CLEAR:  q_exp = 1'b0;
      default:   q_exp = dval_q;
    endcase
  end

  // Reads (including bad indices) are never checked.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) Err <= 1'b0;
    else if (state == S_DONE && op_q != OP_READ && q_sel != q_exp) Err <= 1'b1;
  end
`else
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_ttl_7474_flag_arbiter.sv
// Directed bench for ttl_7474_flag_arbiter with a behavioural 7474 bank.
module tb_ttl_7474_flag_arbiter;
  localparam int BLOCKS = 2, REQUESTERS = 4, IDXW = 3;
  localparam logic [1:0] RD = 2'b00, PR = 2'b01, CL = 2'b10, LD = 2'b11;

  logic Clk = 1'b0;
  logic Reset;
  logic [REQUESTERS-1:0]           Req;
  logic [REQUESTERS-1:0][1:0]      Op;
  logic [REQUESTERS-1:0][IDXW-1:0] Idx;
  logic [REQUESTERS-1:0]           Dval;
  logic [REQUESTERS-1:0]           Gnt, Done;
  logic                            Rdata, Busy, Err;
  logic [BLOCKS-1:0]               FF_D, FF_Clk, Preset_bar, Clear_bar, FF_Q;

  int n_chk = 0;
  int n_fail = 0;
  int lat, pw;
  logic [REQUESTERS-1:0] dv;
  logic force_q1 = 1'b0;

  always #5 Clk = ~Clk;

  ttl_7474_flag_arbiter #(
    .BLOCKS(BLOCKS), .REQUESTERS(REQUESTERS), .PULSE_CYCLES(2),
    .RECOVER_CYCLES(1), .IDXW(IDXW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Op(Op), .Idx(Idx), .Dval(Dval),
    .Gnt(Gnt), .Done(Done), .Rdata(Rdata), .Busy(Busy), .Err(Err),
    .FF_D(FF_D), .FF_Clk(FF_Clk), .Preset_bar(Preset_bar),
    .Clear_bar(Clear_bar), .FF_Q(FF_Q)
  );

  // 7474 bank: async preset/clear, D captured on rising FF_Clk.
  for (genvar b = 0; b < BLOCKS; b++) begin : g_bank
    logic q = 1'b0;
    always @(posedge FF_Clk[b] or negedge Preset_bar[b] or negedge Clear_bar[b]) begin
      if (!Preset_bar[b])     q <= 1'b1;
      else if (!Clear_bar[b]) q <= 1'b0;
      else                    q <= FF_D[b];
    end
    assign FF_Q[b] = (force_q1 && b == 1) ? 1'b0 : q;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, drop Req after it is sampled, run to DONE (bounded),
  // then step into IDLE so Rdata/Err are settled.
  task automatic run_op(input int r, input logic [1:0] op, input logic [IDXW-1:0] idx,
                        input logic d, output int l, output int p,
                        output logic [REQUESTERS-1:0] dn);
    Req = '0; Req[r] = 1'b1; Op[r] = op; Idx[r] = idx; Dval[r] = d;
    l = -1; p = 0; dn = '0;
    for (int c = 1; c <= 20 && l < 0; c++) begin
      tick();
      Req = '0;
      p += $countones(~Preset_bar) + $countones(~Clear_bar) + $countones(FF_Clk);
      if (Done != '0) begin l = c; dn = Done; end
    end
    tick();
  endtask

  initial begin
    Reset = 1'b1; Req = '0; Op = '0; Idx = '0; Dval = '0;
    repeat (2) tick();
    chk("rst_gnt", Gnt, 0);
    chk("rst_done", Done, 0);
    chk("rst_rdata", Rdata, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_err", Err, 0);
    chk("rst_ffd", FF_D, 0);
    chk("rst_ffclk", FF_Clk, 0);
    chk("rst_preset", Preset_bar, 2'b11);
    chk("rst_clear", Clear_bar, 2'b11);
    Reset = 1'b0;
    tick();

    // Preset bit 1 from requester 0, observed cycle by cycle.
    Req[0] = 1'b1; Op[0] = PR; Idx[0] = 1;
    tick(); Req = '0;
    chk("pre_setup_gnt", Gnt, 4'b0001);
    chk("pre_setup_busy", Busy, 1);
    chk("pre_setup_pin", Preset_bar, 2'b11);
    tick(); chk("pre_pulse1", Preset_bar, 2'b01);
    tick(); chk("pre_pulse2", Preset_bar, 2'b01);
    tick(); chk("pre_recover", Preset_bar, 2'b11);
    chk("pre_recover_done", Done, 0);
    tick(); chk("pre_done", Done, 4'b0001);
    chk("pre_done_gnt", Gnt, 4'b0001);
    tick(); chk("pre_idle_done", Done, 0);
    chk("pre_idle_gnt", Gnt, 0);
    chk("pre_idle_busy", Busy, 0);
    chk("pre_rdata", Rdata, 1);

    // Simultaneous requests 0 and 2 from ptr=0.
    Reset = 1'b1; tick(); Reset = 1'b0; tick();
    Req = 4'b0101; Op[0] = RD; Idx[0] = 1; Op[2] = PR; Idx[2] = 0;
    tick(); chk("arb_first", Gnt, 4'b0001); Req[0] = 1'b0;
    tick(); chk("arb_rd_done", Done, 4'b0001);
    tick(); chk("arb_gap_gnt", Gnt, 0);
    chk("arb_gap_busy", Busy, 0);
    chk("arb_rd_rdata", Rdata, 1);
    tick(); chk("arb_second", Gnt, 4'b0100); Req[2] = 1'b0;
    repeat (4) tick();
    chk("arb_second_done", Done, 4'b0100);
    tick(); chk("arb_second_rdata", Rdata, 1);
    // ptr should now be 3: requester 3 beats requester 0.
    Req = 4'b1001; Op[0] = RD; Idx[0] = 0; Op[3] = RD; Idx[3] = 1;
    tick(); chk("ptr3_first", Gnt, 4'b1000); Req[3] = 1'b0;
    tick(); tick();
    tick(); chk("ptr3_wrap", Gnt, 4'b0001); Req[0] = 1'b0;
    tick(); tick();

    // Clear bit 0, then load it with 1.
    run_op(1, CL, 0, 0, lat, pw, dv);
    chk("clr0_lat", lat, 5); chk("clr0_pw", pw, 2); chk("clr0_rdata", Rdata, 0);
    Req[1] = 1'b1; Op[1] = LD; Idx[1] = 0; Dval[1] = 1'b1;
    tick(); Req = '0;
    chk("ld_setup_d", FF_D, 2'b01);
    chk("ld_setup_clk", FF_Clk, 2'b00);
    tick(); chk("ld_pulse1", FF_Clk, 2'b01);
    tick(); chk("ld_pulse2", FF_Clk, 2'b01);
    tick(); chk("ld_recover", FF_Clk, 2'b00);
    tick(); chk("ld_done", Done, 4'b0010);
    tick(); chk("ld_rdata", Rdata, 1);
    run_op(1, CL, 0, 0, lat, pw, dv);
    chk("clr0b_lat", lat, 5); chk("clr0b_done", dv, 4'b0010); chk("clr0b_rdata", Rdata, 0);
    run_op(2, LD, 1, 0, lat, pw, dv);
    chk("ld1_lat", lat, 5); chk("ld1_pw", pw, 2); chk("ld1_rdata", Rdata, 0);
    chk("ld1_ffd", FF_D, 2'b01);

    // Reads, including an out-of-range index.
    run_op(3, PR, 1, 0, lat, pw, dv);
    chk("pre1_rdata", Rdata, 1);
    run_op(0, RD, 5, 0, lat, pw, dv);
    chk("bad_lat", lat, 2); chk("bad_pw", pw, 0);
    chk("bad_done", dv, 4'b0001); chk("bad_rdata", Rdata, 0);
    run_op(1, RD, 1, 0, lat, pw, dv);
    chk("rd1_lat", lat, 2); chk("rd1_rdata", Rdata, 1);

    // Reset in the middle of a clear pulse.
    Req[2] = 1'b1; Op[2] = CL; Idx[2] = 1;
    tick(); Req = '0;
    tick(); chk("rclr_pulse", Clear_bar, 2'b01);
    #2 Reset = 1'b1;
    #1;
    chk("rclr_pin", Clear_bar, 2'b11);
    chk("rclr_gnt", Gnt, 0);
    chk("rclr_busy", Busy, 0);
    chk("rclr_rdata", Rdata, 0);
    tick(); chk("rclr_pin_held", Clear_bar, 2'b11);
    Reset = 1'b0;
    dv = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      dv |= Done;
    end
    chk("rclr_no_done", dv, 0);
    run_op(0, RD, 1, 0, lat, pw, dv);
    chk("rclr_bit", Rdata, 0);

    // Readback mismatch on a preset of bit 1.
`ifdef TTL_7474_ARB_VERIFY_EN
    force_q1 = 1'b1;
`endif
    run_op(1, PR, 1, 0, lat, pw, dv);
    chk("vfy_done", dv, 4'b0010);
`ifdef TTL_7474_ARB_VERIFY_EN
    chk("vfy_err_set", Err, 1);
    chk("vfy_rdata", Rdata, 0);
    force_q1 = 1'b0;
    run_op(2, RD, 1, 0, lat, pw, dv);
    chk("vfy_err_sticky", Err, 1);
`else
    chk("vfy_err_off", Err, 0);
    chk("vfy_rdata", Rdata, 1);
`endif
    Reset = 1'b1; tick();
    chk("vfy_err_rst", Err, 0);
    Reset = 1'b0; tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
